// File: rtl/mult_acc_neuron_if.sv
// Stream interface for mult_acc_neuron: packed operand lanes and bias in,
// rescaled/saturated result out. The master drives operands; the neuron is the slave.
interface mult_acc_neuron_if #(
  parameter int PARALLEL_IN = 4,
  parameter int DATA1_WIDTH = 16,
  parameter int DATA2_WIDTH = 16,
  parameter int OUT_WIDTH   = 32
);
  logic [DATA1_WIDTH*PARALLEL_IN-1:0] din1;
  logic [DATA2_WIDTH*PARALLEL_IN-1:0] din2;
  logic                               din_valid;
  logic                               din_last;
  logic [OUT_WIDTH-1:0]               bias;
  logic [OUT_WIDTH-1:0]               dout;
  logic                               dout_valid;
  logic                               dout_sat;

  modport master (
    output din1, din2, din_valid, din_last, bias,
    input  dout, dout_valid, dout_sat
  );

  modport slave (
    input  din1, din2, din_valid, din_last, bias,
    output dout, dout_valid, dout_sat
  );
endinterface

// File: rtl/mult_acc_neuron.sv
// Streaming dot-product neuron: lane multipliers, pipelined adder tree, framed accumulator
// with bias, saturating rescale. Define MULT_ACC_RELU_EN to clamp negative results to zero.
module mult_acc_neuron #(
  parameter int PARALLEL_IN = 4,
  parameter int DATA1_WIDTH = 16,
  parameter int DATA1_INT   = 2,
  parameter int DATA2_WIDTH = 16,
  parameter int DATA2_INT   = 2,
  parameter int ACC_WIDTH   = 48,
  parameter int OUT_WIDTH   = 32,
  parameter int OUT_INT     = 16
) (
  input  logic             clk,
  input  logic             rst,
  mult_acc_neuron_if.slave bus
);
  localparam int PW = DATA1_WIDTH + DATA2_WIDTH;
  localparam int PP = (DATA1_WIDTH - DATA1_INT) + (DATA2_WIDTH - DATA2_INT);
  localparam int SH = PP - (OUT_WIDTH - OUT_INT);
  localparam int LV = $clog2(PARALLEL_IN);
  localparam int NP = 1 << LV;
  localparam int TW = PW + LV;
  localparam int CW = (ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH;
  localparam logic signed [CW-1:0] SAT_MAX = CW'({1'b0, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

  logic [DATA1_WIDTH*NP-1:0]   din1_pad_s;
  logic [DATA2_WIDTH*NP-1:0]   din2_pad_s;
  logic signed [PW-1:0]        op1_s;
  logic signed [PW-1:0]        op2_s;
  logic signed [PW-1:0]        prod_d [NP];
  logic signed [PW-1:0]        prod_q [NP];
  logic                        m_valid_d, m_valid_q;
  logic                        m_last_d, m_last_q;
  logic signed [OUT_WIDTH-1:0] m_bias_d, m_bias_q;

  // Stage M: lane products; lanes padded up to a power of two multiply zero.
  always_comb begin
    din1_pad_s = (DATA1_WIDTH*NP)'(bus.din1);
    din2_pad_s = (DATA2_WIDTH*NP)'(bus.din2);
    op1_s      = '0;
    op2_s      = '0;
    for (int i = 0; i < NP; i++) begin
      op1_s     = PW'($signed(din1_pad_s[i*DATA1_WIDTH +: DATA1_WIDTH]));
      op2_s     = PW'($signed(din2_pad_s[i*DATA2_WIDTH +: DATA2_WIDTH]));
      prod_d[i] = op1_s * op2_s;
    end
    m_valid_d = bus.din_valid;
    m_last_d  = bus.din_valid & bus.din_last;
    m_bias_d  = bus.bias;
  end

  // Stage M registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) prod_q[i] <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_bias_q  <= '0;
    end else begin
      prod_q    <= prod_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_bias_q  <= m_bias_d;
    end
  end

  logic signed [TW-1:0]        sum_s;
  logic                        t_valid_s;
  logic                        t_last_s;
  logic signed [OUT_WIDTH-1:0] t_bias_s;

  if (LV == 0) begin : g_flat
    assign sum_s     = TW'(prod_q[0]);
    assign t_valid_s = m_valid_q;
    assign t_last_s  = m_last_q;
    assign t_bias_s  = m_bias_q;
  end else begin : g_tree
    logic signed [TW-1:0]        node_s [1:2*NP-1];
    logic signed [TW-1:0]        node_d [1:NP-1];
    logic signed [TW-1:0]        node_q [1:NP-1];
    logic [LV-1:0]               tv_d, tv_q;
    logic [LV-1:0]               tl_d, tl_q;
    logic signed [OUT_WIDTH-1:0] tb_d [LV];
    logic signed [OUT_WIDTH-1:0] tb_q [LV];

    // Heap-ordered tree: node i sums children 2i and 2i+1, leaves live at NP..2NP-1.
    always_comb begin
      for (int i = 1; i < NP; i++) node_s[i] = node_q[i];
      for (int j = 0; j < NP; j++) node_s[NP+j] = TW'(prod_q[j]);
      for (int i = 1; i < NP; i++) node_d[i] = node_s[2*i] + node_s[2*i+1];
      tv_d[0] = m_valid_q;
      tl_d[0] = m_last_q;
      tb_d[0] = m_bias_q;
      for (int k = 1; k < LV; k++) begin
        tv_d[k] = tv_q[k-1];
        tl_d[k] = tl_q[k-1];
        tb_d[k] = tb_q[k-1];
      end
    end

    // Stage T registers: tree nodes plus the valid/last/bias side pipeline.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 1; i < NP; i++) node_q[i] <= '0;
        for (int k = 0; k < LV; k++) tb_q[k] <= '0;
        tv_q <= '0;
        tl_q <= '0;
      end else begin
        node_q <= node_d;
        tb_q   <= tb_d;
        tv_q   <= tv_d;
        tl_q   <= tl_d;
      end
    end

    assign sum_s     = node_q[1];
    assign t_valid_s = tv_q[LV-1];
    assign t_last_s  = tl_q[LV-1];
    assign t_bias_s  = tb_q[LV-1];
  end

  logic signed [ACC_WIDTH-1:0] base_s;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic signed [ACC_WIDTH-1:0] fin_d, fin_q;
  logic                        first_d, first_q;
  logic                        a_valid_d, a_valid_q;

  // Stage A: first beat of a vector restarts from zero, so back-to-back vectors need no bubble.
  always_comb begin
    acc_d     = acc_q;
    fin_d     = fin_q;
    first_d   = first_q;
    a_valid_d = 1'b0;
    base_s    = acc_q;
    if (t_valid_s) begin
      if (first_q) begin
        base_s = '0;
      end else begin
        base_s = acc_q;
      end
      acc_d   = base_s + ACC_WIDTH'(sum_s);
      first_d = t_last_s;
      if (t_last_s) begin
        fin_d     = acc_d + (ACC_WIDTH'(t_bias_s) <<< SH);
        a_valid_d = 1'b1;
      end else begin
        fin_d     = fin_q;
        a_valid_d = 1'b0;
      end
    end else begin
      acc_d     = acc_q;
      first_d   = first_q;
      a_valid_d = 1'b0;
    end
  end

  // Stage A registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      fin_q     <= '0;
      first_q   <= 1'b1;
      a_valid_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      fin_q     <= fin_d;
      first_q   <= first_d;
      a_valid_q <= a_valid_d;
    end
  end

  logic signed [CW-1:0]        shr_s;
  logic [OUT_WIDTH-1:0]        clip_s;
  logic                        clip_sat_s;
  logic                        relu_s;
  logic [OUT_WIDTH-1:0]        dout_d, dout_q;
  logic                        dout_valid_d, dout_valid_q;
  logic                        dout_sat_d, dout_sat_q;

  // Stage O: rescale to the output point (floor), clip, optional ReLU; hold between pulses.
  always_comb begin
    shr_s        = CW'(fin_q) >>> SH;
    clip_s       = shr_s[OUT_WIDTH-1:0];
    clip_sat_s   = 1'b0;
    dout_d       = dout_q;
    dout_sat_d   = dout_sat_q;
    dout_valid_d = a_valid_q;
    if (shr_s > SAT_MAX) begin
      clip_s     = SAT_MAX[OUT_WIDTH-1:0];
      clip_sat_s = 1'b1;
    end else if (shr_s < SAT_MIN) begin
      clip_s     = SAT_MIN[OUT_WIDTH-1:0];
      clip_sat_s = 1'b1;
    end else begin
      clip_s     = shr_s[OUT_WIDTH-1:0];
      clip_sat_s = 1'b0;
    end
`ifdef MULT_ACC_RELU_EN
    relu_s = clip_s[OUT_WIDTH-1];
`else
    relu_s = 1'b0;
`endif
    if (a_valid_q) begin
      if (relu_s) begin
        dout_d     = '0;
        dout_sat_d = 1'b0;
      end else begin
        dout_d     = clip_s;
        dout_sat_d = clip_sat_s;
      end
    end else begin
      dout_d     = dout_q;
      dout_sat_d = dout_sat_q;
    end
  end

  // Stage O registers drive the outputs directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_sat_q   <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_sat_q   <= dout_sat_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_sat   = dout_sat_q;
endmodule

// File: tb/tb_mult_acc_neuron.sv
// Directed bench for mult_acc_neuron: a reference model queues the expected result of each
// vector as it is driven; every output pulse is popped and compared, including its latency.
module tb_mult_acc_neuron;
  localparam int PI  = 4;
  localparam int SH  = 12;
  localparam int LAT = 3 + $clog2(PI);

  typedef struct {
    logic [31:0] dout;
    logic        sat;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  longint      m_acc = 0;
  bit          m_first = 1'b1;
  logic [31:0] last_dout = 32'h0;

  always #5 clk = ~clk;

  mult_acc_neuron_if #(.PARALLEL_IN(PI), .DATA1_WIDTH(16), .DATA2_WIDTH(16), .OUT_WIDTH(32)) bus ();

  mult_acc_neuron #(
    .PARALLEL_IN(PI), .DATA1_WIDTH(16), .DATA1_INT(2), .DATA2_WIDTH(16), .DATA2_INT(2),
    .ACC_WIDTH(48), .OUT_WIDTH(32), .OUT_INT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [63:0] rep4(input logic [15:0] v);
    return {4{v}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; at the falling edge match any output pulse against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (bus.dout_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL spurious_valid observed=%0h expected=no_pulse", bus.dout);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dout", 64'(bus.dout), 64'(e.dout));
        chk("dout_sat", 64'(bus.dout_sat), 64'(e.sat));
        chk("latency", 64'(cyc - e.cyc), 64'(LAT));
        last_dout = e.dout;
      end
    end else if (exp_q.size() != 0) begin
      checks++;
      assert (cyc - exp_q[0].cyc < LAT) else begin
        failures++;
        $error("FAIL pulse_timeout observed=no_pulse expected=%0h", exp_q[0].dout);
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
    repeat (n) tick();
  endtask

  // Drive one valid beat and update the reference model; a last beat queues the expectation.
  task automatic beat(input logic [63:0] d1, input logic [63:0] d2, input logic last,
                      input logic [31:0] b);
    logic signed [15:0] a;
    logic signed [15:0] c;
    longint             t;
    longint             s;
    exp_t               e;
    bus.din1      = d1;
    bus.din2      = d2;
    bus.din_valid = 1'b1;
    bus.din_last  = last;
    bus.bias      = b;
    if (m_first) m_acc = 0;
    for (int i = 0; i < PI; i++) begin
      a = d1[i*16 +: 16];
      c = d2[i*16 +: 16];
      m_acc += longint'(a) * longint'(c);
    end
    m_first = last;
    if (last) begin
      t = m_acc + (longint'($signed(b)) <<< SH);
      s = t >>> SH;
      if (s > 64'sd2147483647) begin
        e.dout = 32'h7FFF_FFFF;
        e.sat  = 1'b1;
      end else if (s < -64'sd2147483648) begin
        e.dout = 32'h8000_0000;
        e.sat  = 1'b1;
      end else begin
        e.dout = s[31:0];
        e.sat  = 1'b0;
      end
`ifdef MULT_ACC_RELU_EN
      if (e.dout[31]) begin
        e.dout = 32'h0;
        e.sat  = 1'b0;
      end
`endif
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    tick();
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
  endtask

  initial begin
    bus.din1      = 64'h0;
    bus.din2      = 64'h0;
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
    bus.bias      = 32'h0;
    rst           = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    tick();
    chk("rst_dout", 64'(bus.dout), 64'h0);
    chk("rst_valid", 64'(bus.dout_valid), 64'h0);
    chk("rst_sat", 64'(bus.dout_sat), 64'h0);
    rst = 1'b1;
    idle(2);

    // Single-beat vector: 4 x (1.0 * 0.5) = 2.0
    beat(rep4(16'd16384), rep4(16'd8192), 1'b1, 32'h0);
    idle(8);

    // Two beats with a gap, bias 1.0 -> 5.0
    beat(rep4(16'd16384), rep4(16'd8192), 1'b0, 32'h0);
    idle(1);
    beat(rep4(16'd16384), rep4(16'd8192), 1'b1, 32'h0001_0000);
    idle(8);

    // Back-to-back single-beat vectors: +2.0 then -2.0
    beat(rep4(16'd16384), rep4(16'd8192), 1'b1, 32'h0);
    beat(rep4(16'd16384), rep4(16'hE000), 1'b1, 32'h0);
    idle(8);
    chk("dout_hold", 64'(bus.dout), 64'(last_dout));

    // Positive saturation: 2100 beats of 16.0
    for (int i = 0; i < 2100; i++) begin
      beat(rep4(16'h8000), rep4(16'h8000), (i == 2099), 32'h0);
    end
    idle(8);

    // Negative saturation with a gap mid-vector
    for (int i = 0; i < 2100; i++) begin
      beat(rep4(16'h8000), rep4(16'h7FFF), (i == 2099), 32'h0);
      if (i == 1000) idle(3);
    end
    idle(8);

    // Random vectors of 1..4 beats with random gaps and bias
    for (int v = 0; v < 4; v++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        beat({$urandom, $urandom}, {$urandom, $urandom}, (b == nb - 1), $urandom);
        if ($urandom_range(0, 1) == 1) idle(1);
      end
    end
    idle(8);

    // Reset in the middle of a vector: in-flight beats are discarded
    for (int i = 0; i < 3; i++) begin
      beat(rep4(16'd16384), rep4(16'd8192), 1'b0, 32'h0);
    end
    rst       = 1'b0;
    m_first   = 1'b1;
    m_acc     = 0;
    last_dout = 32'h0;
    tick();
    chk("mid_rst_dout", 64'(bus.dout), 64'h0);
    chk("mid_rst_valid", 64'(bus.dout_valid), 64'h0);
    rst = 1'b1;
    beat(rep4(16'd16384), rep4(16'd8192), 1'b1, 32'h0);
    idle(10);

    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
